// File: rtl/eth_latency_ping_scheduler.sv
// ----------------------------------------------------------------------------
// eth_latency_ping_scheduler
// Sequences the latency measurer's ping/pong exchange. It requests a ping from
// the frame transmitter and timestamps its departure. It then waits for the
// matching pong or a timeout, and afterwards waits the inter-ping delay. It
// also keeps the ping, RTT and loss statistics that the register block reads.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable, srst      run scheduler / synchronous soft reset (register bits)
//   delay             idle cycles between end of one exchange and next ping
//   timeout           cycles to wait for pong after ping departure
//   current_time      free-running timestamp
//   tx_req/tx_seq     ping request (held until tx_ack) and its sequence number
//   tx_ack, tx_done   TX accepted request / ping's first byte left MAC
//   rx_pong_valid/seq pong received and its sequence number
//   ping_count        pings acknowledged by TX
//   rtt               last round-trip time in cycles
//   pings_lost        exchanges ended by timeout
//   stale_pongs       pongs not matching the in-flight ping or arriving late
//   result_valid      1-cycle pulse: rtt updated or loss counted
//   busy              scheduler not idle
// ----------------------------------------------------------------------------
module eth_latency_ping_scheduler #(
   parameter int unsigned C_SEQ_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   srst,
   input  logic [31:0]            delay,
   input  logic [31:0]            timeout,
   input  logic [63:0]            current_time,
   output logic                   tx_req,
   output logic [C_SEQ_WIDTH-1:0] tx_seq,
   input  logic                   tx_ack,
   input  logic                   tx_done,
   input  logic                   rx_pong_valid,
   input  logic [C_SEQ_WIDTH-1:0] rx_pong_seq,
   output logic [C_SEQ_WIDTH-1:0] ping_count,
   output logic [31:0]            rtt,
   output logic [C_SEQ_WIDTH-1:0] pings_lost,
   output logic [C_SEQ_WIDTH-1:0] stale_pongs,
   output logic                   result_valid,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_TX,
      S_WAIT_RX,
      S_GAP
   } state_t;

   state_t                 state_q, state_d;
   logic [C_SEQ_WIDTH-1:0] ping_count_q, ping_count_d;
   logic [C_SEQ_WIDTH-1:0] inflight_q, inflight_d;
   logic [C_SEQ_WIDTH-1:0] lost_q, lost_d;
   logic [C_SEQ_WIDTH-1:0] stale_q, stale_d;
   logic [31:0]            t_sent_q, t_sent_d;
   logic [31:0]            wait_q, wait_d;
   logic [31:0]            gap_q, gap_d;
   logic [31:0]            rtt_q, rtt_d;
   logic                   rv_q, rv_d;
   logic                   tx_req_q, tx_req_d;
   logic                   busy_q, busy_d;
   logic [31:0]            tmo_eff;
   logic                   pong_match;

   assign tmo_eff    = (timeout == '0) ? 32'd1 : timeout;
   assign pong_match = rx_pong_valid && (state_q == S_WAIT_RX) && (rx_pong_seq == inflight_q);

   always_comb begin
      state_d      = state_q;
      ping_count_d = ping_count_q;
      inflight_d   = inflight_q;
      lost_d       = lost_q;
      stale_d      = stale_q;
      t_sent_d     = t_sent_q;
      wait_d       = wait_q;
      gap_d        = gap_q;
      rtt_d        = rtt_q;
      rv_d         = 1'b0;

      if (rx_pong_valid && !pong_match) begin
         stale_d = stale_q + C_SEQ_WIDTH'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_REQ;
         end
         S_REQ: begin
            if (tx_ack) begin
               inflight_d   = ping_count_q;
               ping_count_d = ping_count_q + C_SEQ_WIDTH'(1);
               state_d      = S_WAIT_TX;
            end
         end
         S_WAIT_TX: begin
            if (tx_done) begin
               t_sent_d = current_time[31:0];
               wait_d   = '0;
               state_d  = S_WAIT_RX;
            end
         end
         S_WAIT_RX: begin
            wait_d = wait_q + 32'd1;
            // A pong arriving on the timeout cycle still counts as a valid RTT.
            if (pong_match) begin
               rtt_d   = current_time[31:0] - t_sent_q;
               rv_d    = 1'b1;
               gap_d   = '0;
               state_d = S_GAP;
            end else if (wait_q + 32'd1 >= tmo_eff) begin
               lost_d  = lost_q + C_SEQ_WIDTH'(1);
               rv_d    = 1'b1;
               gap_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            // Stay delay+1 cycles, so delay=0 still spends one cycle here.
            gap_d = gap_q + 32'd1;
            if (gap_q >= delay) state_d = enable ? S_REQ : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      tx_req_d = (state_d == S_REQ);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ping_count_q <= '0;
         inflight_q   <= '0;
         lost_q       <= '0;
         stale_q      <= '0;
         t_sent_q     <= '0;
         wait_q       <= '0;
         gap_q        <= '0;
         rtt_q        <= '0;
         rv_q         <= 1'b0;
         tx_req_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else if (srst) begin
         state_q      <= S_IDLE;
         ping_count_q <= '0;
         inflight_q   <= '0;
         lost_q       <= '0;
         stale_q      <= '0;
         t_sent_q     <= '0;
         wait_q       <= '0;
         gap_q        <= '0;
         rtt_q        <= '0;
         rv_q         <= 1'b0;
         tx_req_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ping_count_q <= ping_count_d;
         inflight_q   <= inflight_d;
         lost_q       <= lost_d;
         stale_q      <= stale_d;
         t_sent_q     <= t_sent_d;
         wait_q       <= wait_d;
         gap_q        <= gap_d;
         rtt_q        <= rtt_d;
         rv_q         <= rv_d;
         tx_req_q     <= tx_req_d;
         busy_q       <= busy_d;
      end
   end

   assign tx_req       = tx_req_q;
   assign tx_seq       = ping_count_q;
   assign ping_count   = ping_count_q;
   assign rtt          = rtt_q;
   assign pings_lost   = lost_q;
   assign stale_pongs  = stale_q;
   assign result_valid = rv_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_eth_latency_ping_scheduler.sv
// ----------------------------------------------------------------------------
// tb_eth_latency_ping_scheduler
// Directed stimulus for the ping scheduler. An exchange-level model, tracked
// with absolute cycle deadlines, is compared against every output each cycle.
// Hand-computed literals additionally pin RTT, loss latency and gap latency.
// ----------------------------------------------------------------------------
module tb_eth_latency_ping_scheduler;
   localparam int W = 64;

   localparam int PH_IDLE = 0;
   localparam int PH_REQ  = 1;
   localparam int PH_TX   = 2;
   localparam int PH_RX   = 3;
   localparam int PH_GAP  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          srst = 1'b0;
   logic [31:0]   delay = 32'd10;
   logic [31:0]   timeout = 32'd100;
   logic [63:0]   current_time = 64'h0000_0000_FFFF_FFE0;
   logic          tx_req;
   logic [W-1:0]  tx_seq;
   logic          tx_ack = 1'b0;
   logic          tx_done = 1'b0;
   logic          rx_pong_valid = 1'b0;
   logic [W-1:0]  rx_pong_seq = '0;
   logic [W-1:0]  ping_count;
   logic [31:0]   rtt;
   logic [W-1:0]  pings_lost;
   logic [W-1:0]  stale_pongs;
   logic          result_valid;
   logic          busy;

   eth_latency_ping_scheduler #(.C_SEQ_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .srst(srst),
      .delay(delay), .timeout(timeout), .current_time(current_time),
      .tx_req(tx_req), .tx_seq(tx_seq), .tx_ack(tx_ack), .tx_done(tx_done),
      .rx_pong_valid(rx_pong_valid), .rx_pong_seq(rx_pong_seq),
      .ping_count(ping_count), .rtt(rtt), .pings_lost(pings_lost),
      .stale_pongs(stale_pongs), .result_valid(result_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   int     rv_seen = 0;

   // model state
   int          m_phase = PH_IDLE;
   logic [W-1:0] m_count = '0, m_lost = '0, m_stale = '0, m_inflight = '0;
   logic [31:0] m_rtt = '0, m_tsent = '0;
   longint      m_deadline = 0, m_gapend = 0;
   logic        m_rv = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Exchange-level model evaluated at each rising edge with the sampled inputs.
   task automatic model_step();
      logic match;
      m_rv = 1'b0;
      if (!rst_n || srst) begin
         m_phase = PH_IDLE; m_count = '0; m_lost = '0; m_stale = '0;
         m_inflight = '0; m_rtt = '0; m_tsent = '0;
         return;
      end
      match = (m_phase == PH_RX) && rx_pong_valid && (rx_pong_seq == m_inflight);
      if (rx_pong_valid && !match) m_stale = m_stale + 1;
      case (m_phase)
         PH_IDLE: if (enable) m_phase = PH_REQ;
         PH_REQ: if (tx_ack) begin
            m_inflight = m_count;
            m_count = m_count + 1;
            m_phase = PH_TX;
         end
         PH_TX: if (tx_done) begin
            m_tsent = current_time[31:0];
            m_deadline = cyc + ((timeout == 0) ? 1 : longint'(timeout));
            m_phase = PH_RX;
         end
         PH_RX: begin
            if (match || cyc >= m_deadline) begin
               if (match) m_rtt = current_time[31:0] - m_tsent;
               else       m_lost = m_lost + 1;
               m_rv = 1'b1;
               m_gapend = cyc + longint'(delay) + 1;
               m_phase = PH_GAP;
            end
         end
         PH_GAP: if (cyc >= m_gapend) m_phase = enable ? PH_REQ : PH_IDLE;
         default: m_phase = PH_IDLE;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
         #1;
         check("tx_req",       64'(tx_req),       64'(m_phase == PH_REQ));
         check("busy",         64'(busy),         64'(m_phase != PH_IDLE));
         check("tx_seq",       tx_seq,            m_count);
         check("ping_count",   ping_count,        m_count);
         check("rtt",          64'(rtt),          64'(m_rtt));
         check("pings_lost",   pings_lost,        m_lost);
         check("stale_pongs",  stale_pongs,       m_stale);
         check("result_valid", 64'(result_valid), 64'(m_rv));
         if (result_valid) rv_seen++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         current_time = current_time + 64'd1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_ack();
      tx_ack = 1'b1; tick(); tx_ack = 1'b0;
   endtask

   task automatic pulse_done();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
   endtask

   task automatic pulse_pong(input logic [W-1:0] s);
      rx_pong_seq = s; rx_pong_valid = 1'b1; tick(); rx_pong_valid = 1'b0;
   endtask

   task automatic wait_req();
      int i = 0;
      while (!tx_req && i < 100) begin tick(); i++; end
      check("wait_tx_req", 64'(tx_req), 64'd1);
   endtask

   task automatic wait_rv();
      int i = 0;
      while (!result_valid && i < 300) begin tick(); i++; end
      check("wait_result_valid", 64'(result_valid), 64'd1);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy && i < 100) begin tick(); i++; end
      check("wait_idle", 64'(busy), 64'd0);
   endtask

   longint d, r, p;

   initial begin
      // reset
      repeat (3) tick();
      check("rst_tx_req", 64'(tx_req), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ping_count", ping_count, 64'd0);
      rst_n = 1'b1;
      tick();

      // exchange with pong after 35 cycles; enable drops mid-exchange
      enable = 1'b1;
      wait_req();
      repeat (2) tick();
      pulse_ack();
      repeat (2) tick();
      pulse_done();
      repeat (4) tick();
      enable = 1'b0;
      repeat (30) tick();
      pulse_pong('0);
      wait_idle();
      check("t1_rtt", 64'(rtt), 64'd35);
      check("t1_ping_count", ping_count, 64'd1);
      check("t1_pings_lost", pings_lost, 64'd0);
      check("t1_rv_pulses", 64'(rv_seen), 64'd1);

      // timeout: loss 100 cycles after departure, next request 11 cycles later
      enable = 1'b1;
      wait_req();
      repeat (2) tick();
      pulse_ack();
      tick();
      d = cyc + 1;
      pulse_done();
      wait_rv();
      check("t2_loss_latency", 64'(cyc - d), 64'd100);
      check("t2_pings_lost", pings_lost, 64'd1);
      r = cyc;
      wait_req();
      check("t2_gap_latency", 64'(cyc - r), 64'd11);

      // pong on the exact timeout cycle wins
      tick();
      pulse_ack();
      d = cyc + 1;
      pulse_done();
      enable = 1'b0;
      while (cyc + 1 < d + 100) tick();
      pulse_pong(64'd2);
      wait_idle();
      check("t3_pings_lost", pings_lost, 64'd1);
      check("t3_rtt", 64'(rtt), 64'd100);
      check("t3_ping_count", ping_count, 64'd3);

      // stale pong with wrong seq, then matching pong, then a pong while idle
      enable = 1'b1;
      wait_req();
      check("t4_tx_seq", tx_seq, 64'd3);
      tick();
      pulse_ack();
      tick();
      d = cyc + 1;
      pulse_done();
      enable = 1'b0;
      repeat (5) tick();
      pulse_pong(64'd7);
      repeat (5) tick();
      p = cyc + 1;
      pulse_pong(64'd3);
      wait_idle();
      check("t4_stale", stale_pongs, 64'd1);
      check("t4_rtt", 64'(rtt), 64'd12);
      check("t4_rtt_span", 64'(p - d), 64'd12);
      pulse_pong(64'd3);
      check("t4_stale_idle", stale_pongs, 64'd2);

      // soft reset while a request is pending
      enable = 1'b1;
      wait_req();
      srst = 1'b1;
      enable = 1'b0;
      tick();
      srst = 1'b0;
      check("t5_tx_req", 64'(tx_req), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_ping_count", ping_count, 64'd0);
      check("t5_stale", stale_pongs, 64'd0);
      check("t5_lost", pings_lost, 64'd0);
      check("t5_rtt", 64'(rtt), 64'd0);

      // timeout=0 and delay=0 behave as one cycle each
      timeout = 32'd0;
      delay = 32'd0;
      enable = 1'b1;
      wait_req();
      check("t6_tx_seq", tx_seq, 64'd0);
      tick();
      pulse_ack();
      d = cyc + 1;
      pulse_done();
      enable = 1'b0;
      wait_rv();
      check("t6_loss_latency", 64'(cyc - d), 64'd1);
      check("t6_pings_lost", pings_lost, 64'd1);
      tick();
      tick();
      check("t6_idle_after_gap", 64'(busy), 64'd0);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
